rule_conf_master: RTL and testbench

//  Host-side initiator for the per-layer rule configuration bus of the parser pipeline.

---
 rtl/rule_conf_master.sv | 197 +++++++++++++++++++
 tb/tb_rule_conf_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rule_conf_master.sv
// Host-side initiator for the per-layer rule configuration bus: one command in flight,
// one strobe per command, one response per command. Optional read timeout: CONF_RD_TIMEOUT_EN.
module rule_conf_master #(
    parameter int unsigned LAYER_NUM      = 4,
    parameter int unsigned LAYER_ID_WIDTH = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_wr,
    input  logic [LAYER_ID_WIDTH-1:0] i_cmd_layer,
    input  logic [31:0]               i_cmd_addr,
    input  logic [31:0]               i_cmd_wdata,
    output logic                      o_resp_valid,
    input  logic                      i_resp_ready,
    output logic [31:0]               o_resp_data,
    output logic                      o_resp_err,
    output logic [LAYER_NUM-1:0]      o_rule_wren,
    output logic [LAYER_NUM-1:0]      o_rule_rden,
    output logic [31:0]               o_rule_addr,
    output logic [31:0]               o_rule_wdata,
    input  logic [LAYER_NUM-1:0]      i_rule_rdata_valid,
    input  logic [LAYER_NUM*32-1:0]   i_rule_rdata,
    output logic                      o_busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StResp} state_e;

    state_e                    state_q, state_d;
    logic                      cmd_wr_q, cmd_wr_d;
    logic                      cmd_bad_q, cmd_bad_d;
    logic [LAYER_ID_WIDTH-1:0] cmd_layer_q, cmd_layer_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      resp_valid_q, resp_valid_d;
    logic                      resp_err_q, resp_err_d;
    logic [31:0]               resp_data_q, resp_data_d;
    logic [LAYER_NUM-1:0]      wren_q, wren_d;
    logic [LAYER_NUM-1:0]      rden_q, rden_d;
    logic [31:0]               addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic                      busy_q, busy_d;

`ifdef CONF_RD_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntWidth-1:0] cnt_q, cnt_d;
`endif

    logic [LAYER_NUM-1:0] cmd_onehot;
    logic                 sel_valid;
    logic [31:0]          sel_data;

    // An out-of-range layer id decodes to an all-zero one-hot, which also flags it as bad.
    always_comb begin
        cmd_onehot = '0;
        sel_valid  = 1'b0;
        sel_data   = '0;
        for (int k = 0; k < int'(LAYER_NUM); k++) begin
            if (i_cmd_layer == LAYER_ID_WIDTH'(k)) cmd_onehot[k] = 1'b1;
            if (cmd_layer_q == LAYER_ID_WIDTH'(k)) begin
                sel_valid = i_rule_rdata_valid[k];
                sel_data  = i_rule_rdata[k*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_wr_d     = cmd_wr_q;
        cmd_bad_d    = cmd_bad_q;
        cmd_layer_d  = cmd_layer_q;
        cmd_ready_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        wren_d       = '0;
        rden_d       = '0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
`ifdef CONF_RD_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (i_cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    cmd_wr_d    = i_cmd_wr;
                    cmd_bad_d   = ~|cmd_onehot;
                    cmd_layer_d = i_cmd_layer;
                    addr_d      = i_cmd_addr;
                    wdata_d     = i_cmd_wdata;
                    if (i_cmd_wr) wren_d = cmd_onehot;
                    else          rden_d = cmd_onehot;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (cmd_bad_q || cmd_wr_q) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = cmd_bad_q;
                    resp_data_d  = '0;
                    state_d      = StResp;
                end else if (sel_valid) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = sel_data;
                    state_d      = StResp;
                end else begin
                    state_d = StWaitRd;
`ifdef CONF_RD_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StWaitRd: begin
                if (sel_valid) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = sel_data;
                    state_d      = StResp;
                end
`ifdef CONF_RD_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntWidth'(TIMEOUT_CYCLES)) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                        state_d      = StResp;
                    end
                end
`endif
            end
            StResp: begin
                if (i_resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_data_d  = '0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            cmd_wr_q     <= 1'b0;
            cmd_bad_q    <= 1'b0;
            cmd_layer_q  <= '0;
            cmd_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            wren_q       <= '0;
            rden_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
`ifdef CONF_RD_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_wr_q     <= cmd_wr_d;
            cmd_bad_q    <= cmd_bad_d;
            cmd_layer_q  <= cmd_layer_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            wren_q       <= wren_d;
            rden_q       <= rden_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
`ifdef CONF_RD_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign o_cmd_ready  = cmd_ready_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_err   = resp_err_q;
    assign o_resp_data  = resp_data_q;
    assign o_rule_wren  = wren_q;
    assign o_rule_rden  = rden_q;
    assign o_rule_addr  = addr_q;
    assign o_rule_wdata = wdata_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_rule_conf_master.sv
// Randomized self-checking bench for rule_conf_master (LAYER_NUM=3 so layer id 3 is invalid).
module tb_rule_conf_master;

    localparam int unsigned LN = 3;
    localparam int unsigned LW = 2;
    localparam int unsigned TO = 16;
`ifdef CONF_RD_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_cmd_valid = 1'b0;
    logic             o_cmd_ready;
    logic             i_cmd_wr = 1'b0;
    logic [LW-1:0]    i_cmd_layer = '0;
    logic [31:0]      i_cmd_addr = '0;
    logic [31:0]      i_cmd_wdata = '0;
    logic             o_resp_valid;
    logic             i_resp_ready = 1'b0;
    logic [31:0]      o_resp_data;
    logic             o_resp_err;
    logic [LN-1:0]    o_rule_wren;
    logic [LN-1:0]    o_rule_rden;
    logic [31:0]      o_rule_addr;
    logic [31:0]      o_rule_wdata;
    logic [LN-1:0]    i_rule_rdata_valid = '0;
    logic [LN*32-1:0] i_rule_rdata = '0;
    logic             o_busy;

    int total = 0;
    int bad   = 0;

    rule_conf_master #(
        .LAYER_NUM      (LN),
        .LAYER_ID_WIDTH (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_cmd_valid        (i_cmd_valid),
        .o_cmd_ready        (o_cmd_ready),
        .i_cmd_wr           (i_cmd_wr),
        .i_cmd_layer        (i_cmd_layer),
        .i_cmd_addr         (i_cmd_addr),
        .i_cmd_wdata        (i_cmd_wdata),
        .o_resp_valid       (o_resp_valid),
        .i_resp_ready       (i_resp_ready),
        .o_resp_data        (o_resp_data),
        .o_resp_err         (o_resp_err),
        .o_rule_wren        (o_rule_wren),
        .o_rule_rden        (o_rule_rden),
        .o_rule_addr        (o_rule_addr),
        .o_rule_wdata       (o_rule_wdata),
        .i_rule_rdata_valid (i_rule_rdata_valid),
        .i_rule_rdata       (i_rule_rdata),
        .o_busy             (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(o_cmd_ready), 0);
        check({tag, "_rvalid"}, 32'(o_resp_valid), 0);
        check({tag, "_rerr"}, 32'(o_resp_err), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_wren"}, 32'(o_rule_wren), 0);
        check({tag, "_rden"}, 32'(o_rule_rden), 0);
        check({tag, "_addr"}, o_rule_addr, 0);
        check({tag, "_wdata"}, o_rule_wdata, 0);
        check({tag, "_rdata"}, o_resp_data, 0);
    endtask

    // Responder for one cycle: the target layer only answers at cycle hit_k unless noise
    // on it is allowed; other layers toggle randomly and must be ignored.
    task automatic drive_rd(input int k, input int hit_k, input int layer,
                            input logic [31:0] data, input bit target_noise);
        for (int j = 0; j < int'(LN); j++) begin
            if (j == layer && k == hit_k) begin
                i_rule_rdata_valid[j]    = 1'b1;
                i_rule_rdata[j*32 +: 32] = data;
            end else if (j == layer && !target_noise) begin
                i_rule_rdata_valid[j]    = 1'b0;
                i_rule_rdata[j*32 +: 32] = $urandom;
            end else begin
                i_rule_rdata_valid[j]    = 1'($urandom_range(0, 1));
                i_rule_rdata[j*32 +: 32] = $urandom;
            end
        end
    endtask

    // One full command; d = cycles after the strobe cycle before the read answer
    // (0 = same cycle as the strobe), r = cycles the host withholds i_resp_ready.
    task automatic run_cmd(input bit wr, input int layer, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd,
                           input int d, input int r);
        bit            ok = (layer < int'(LN));
        bit            rd_ok = ok && !wr;
        logic [LN-1:0] es = '0;
        int            k, w, hit, exp_lat, extra;
        logic [31:0]   exp_data;
        bit            exp_err, got;

        if (ok) es[layer] = 1'b1;
        hit      = rd_ok ? 1 + d : -1;
        exp_lat  = rd_ok ? 2 + d : 2;
        exp_err  = !ok;
        exp_data = rd_ok ? rd : 32'h0;
        if (rd_ok && TimeoutEn && d > int'(TO)) begin
            exp_lat  = 2 + int'(TO);
            exp_err  = 1'b1;
            exp_data = 32'h0;
        end

        w = 0;
        while (!o_cmd_ready && w < 20) begin
            tick();
            w++;
        end
        check("idle_ready", 32'(o_cmd_ready), 1);
        check("idle_busy", 32'(o_busy), 0);

        i_cmd_valid = 1'b1;
        i_cmd_wr    = wr;
        i_cmd_layer = LW'(layer);
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd_wr    = 1'($urandom_range(0, 1));
        i_cmd_layer = LW'($urandom_range(0, 3));
        i_cmd_addr  = $urandom;
        i_cmd_wdata = $urandom;

        k = 1;
        check("iss_wren", 32'(o_rule_wren), wr ? 32'(es) : 0);
        check("iss_rden", 32'(o_rule_rden), wr ? 0 : 32'(es));
        check("iss_addr", o_rule_addr, addr);
        check("iss_wdata", o_rule_wdata, wdata);
        check("iss_busy", 32'(o_busy), 1);
        check("iss_ready", 32'(o_cmd_ready), 0);
        check("iss_rvalid", 32'(o_resp_valid), 0);
        drive_rd(k, hit, layer, rd, !rd_ok);

        got   = 1'b0;
        extra = 0;
        while (!got && k < 60) begin
            tick();
            k++;
            if ((o_rule_wren | o_rule_rden) != '0) extra++;
            if (o_resp_valid) got = 1'b1;
            else drive_rd(k, hit, layer, rd, !rd_ok);
        end
        check("strobe_once", 32'(extra), 0);
        check("resp_lat", 32'(k), 32'(exp_lat));
        check("resp_data", o_resp_data, exp_data);
        check("resp_err", 32'(o_resp_err), 32'(exp_err));
        check("hold_addr", o_rule_addr, addr);

        for (int i = 0; i < r; i++) begin
            drive_rd(k, -1, layer, 32'h0, 1'b1);
            tick();
            check("hold_valid", 32'(o_resp_valid), 1);
            check("hold_data", o_resp_data, exp_data);
            check("hold_err", 32'(o_resp_err), 32'(exp_err));
        end

        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
        i_rule_rdata_valid = '0;
        check("post_rvalid", 32'(o_resp_valid), 0);
        check("post_ready", 32'(o_cmd_ready), 0);
        check("post_busy", 32'(o_busy), 0);
        tick();
        check("post_ready2", 32'(o_cmd_ready), 1);
        check("post_rvalid2", 32'(o_resp_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held three cycles, then ready appears one edge after release.
        for (int i = 0; i < 3; i++) tick();
        check_all_zero("rst");
        i_rst = 1'b0;
        check("rel_ready0", 32'(o_cmd_ready), 0);
        tick();
        check("rel_ready1", 32'(o_cmd_ready), 1);

        run_cmd(1'b1, 2, 32'h10, 32'hA5A5_0001, 32'h0, 0, 0);
        run_cmd(1'b0, 1, 32'h4, 32'h0, 32'h1234_5678, 3, 5);
        run_cmd(1'b0, 0, 32'h8, 32'h0, 32'h0000_CAFE, 2, 1);
        run_cmd(1'b0, 0, 32'hC, 32'h0, 32'h0000_BEEF, 0, 0);
        run_cmd(1'b1, 3, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 2);
        run_cmd(1'b0, 3, 32'h24, 32'h0, 32'h5555_AAAA, 0, 0);
        run_cmd(1'b0, 2, 32'h30, 32'h0, 32'h0BAD_F00D, int'(TO), 0);
        run_cmd(1'b0, 1, 32'h34, 32'h0, 32'h7777_1111, int'(TO) + 4, 1);

        for (int n = 0; n < 40; n++) begin
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom, $urandom,
                    $urandom, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
        end

        // Reset during the strobe cycle clears the strobe at once.
        i_cmd_valid = 1'b1;
        i_cmd_wr    = 1'b1;
        i_cmd_layer = 2'd1;
        i_cmd_addr  = 32'h40;
        i_cmd_wdata = 32'h1;
        tick();
        i_cmd_valid = 1'b0;
        check("mid_strobe", 32'(o_rule_wren), 32'b010);
        i_rst = 1'b1;
        #1;
        check_all_zero("rst_iss");
        tick();
        i_rst = 1'b0;
        tick();

        // Reset while waiting for read data drops the command without a response.
        i_cmd_valid = 1'b1;
        i_cmd_wr    = 1'b0;
        i_cmd_layer = 2'd0;
        i_cmd_addr  = 32'h44;
        tick();
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("wait_busy", 32'(o_busy), 1);
        i_rst = 1'b1;
        #1;
        check_all_zero("rst_wait");
        tick();
        i_rst = 1'b0;
        i_rule_rdata_valid = '1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_resp", 32'(o_resp_valid), 0);
        end
        check("rec_ready", 32'(o_cmd_ready), 1);
        i_rule_rdata_valid = '0;
        run_cmd(1'b0, 2, 32'h48, 32'h0, 32'h600D_0001, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
